// File: rtl/prog_clock_divider.sv
// Programmable clock divider: square or single-pulse output, period-boundary divisor reloads, graceful stop.
// Optional PROG_CLOCK_DIVIDER_PERIOD_CNT_EN adds a periodCnt output counting output periods.
module prog_clock_divider #(
   parameter int   CNT_W    = 16,
   parameter int   DEF_DIV  = 4,
   parameter logic DEF_MODE = 1'b0
) (
   input  logic             clkIn,
   input  logic             rst,
   input  logic             en,
   input  logic [CNT_W-1:0] divIn,
   input  logic             modeIn,
   input  logic             divLoad,
   output logic             clkOut,
   output logic             tick,
   output logic             running,
   output logic             pending,
`ifdef PROG_CLOCK_DIVIDER_PERIOD_CNT_EN
   output logic [CNT_W-1:0] periodCnt,
`endif
   output logic             cfgErr
);

   localparam logic [1:0] IDLE = 2'd0;
   localparam logic [1:0] RUN  = 2'd1;
   localparam logic [1:0] STOP = 2'd2;

   logic [1:0]       state, nState;
   logic [CNT_W-1:0] cnt, nCnt;
   logic [CNT_W-1:0] divAct, nDivAct;
   logic             modeAct, nModeAct;
   logic [CNT_W-1:0] shadowDiv, nShadowDiv;
   logic             shadowMode, nShadowMode;
   logic             nPending, nCfgErr;
   logic             nClkOut, nTick;
   logic             atBoundary, loadOk, loadBad;

   // Next-state logic; outputs are computed from next-state values so they can be registered
   always_comb begin
      nState      = state;
      nCnt        = cnt;
      nDivAct     = divAct;
      nModeAct    = modeAct;
      nShadowDiv  = shadowDiv;
      nShadowMode = shadowMode;
      nPending    = pending;
      nCfgErr     = cfgErr;
      atBoundary  = (cnt >= (divAct - CNT_W'(1)));
      loadOk      = divLoad && (divIn >= CNT_W'(2));
      loadBad     = divLoad && (divIn < CNT_W'(2));

      case (state)
         RUN, STOP: begin
            if (atBoundary) begin
               nCnt = '0;
               if (pending) begin
                  nDivAct  = shadowDiv;
                  nModeAct = shadowMode;
                  nPending = 1'b0;
               end
            end else begin
               nCnt = cnt + CNT_W'(1);
            end
            if (state == RUN) begin
               if (!en) nState = STOP;
            end else if (en) begin
               nState = RUN;
            end else if (atBoundary) begin
               nState = IDLE;
            end
            // A load arriving in the boundary cycle itself waits for the following boundary
            if (loadOk) begin
               nShadowDiv  = divIn;
               nShadowMode = modeIn;
               nPending    = 1'b1;
            end
         end
         default: begin
            nCnt = '0;
            if (pending) begin
               nDivAct  = shadowDiv;
               nModeAct = shadowMode;
               nPending = 1'b0;
            end
            if (loadOk) begin
               nShadowDiv  = divIn;
               nShadowMode = modeIn;
               nDivAct     = divIn;
               nModeAct    = modeIn;
               nPending    = 1'b0;
            end
            if (en) nState = RUN;
         end
      endcase

      if (loadOk)  nCfgErr = 1'b0;
      if (loadBad) nCfgErr = 1'b1;

      nTick   = (nState != IDLE) && (nCnt == '0);
      nClkOut = (nState != IDLE) &&
                (nModeAct ? (nCnt == '0) : (nCnt < (nDivAct >> 1)));
   end

   // State and registered outputs, cleared asynchronously by reset
   always_ff @(posedge clkIn or negedge rst) begin
      if (!rst) begin
         state      <= IDLE;
         cnt        <= '0;
         divAct     <= CNT_W'(DEF_DIV);
         modeAct    <= DEF_MODE;
         shadowDiv  <= CNT_W'(DEF_DIV);
         shadowMode <= DEF_MODE;
         pending    <= 1'b0;
         cfgErr     <= 1'b0;
         clkOut     <= 1'b0;
         tick       <= 1'b0;
         running    <= 1'b0;
      end else begin
         state      <= nState;
         cnt        <= nCnt;
         divAct     <= nDivAct;
         modeAct    <= nModeAct;
         shadowDiv  <= nShadowDiv;
         shadowMode <= nShadowMode;
         pending    <= nPending;
         cfgErr     <= nCfgErr;
         clkOut     <= nClkOut;
         tick       <= nTick;
         running    <= (nState != IDLE);
      end
   end

`ifdef PROG_CLOCK_DIVIDER_PERIOD_CNT_EN
   // Counts output periods alongside tick; holds while idle
   always_ff @(posedge clkIn or negedge rst) begin
      if (!rst) begin
         periodCnt <= '0;
      end else if (nTick) begin
         periodCnt <= periodCnt + CNT_W'(1);
      end
   end
`endif

endmodule

// File: tb/tb_prog_clock_divider.sv
// Directed self-checking bench for prog_clock_divider (default build, CNT_W = 16, DEF_DIV = 4, square).
module tb_prog_clock_divider;

   logic        clkIn;
   logic        rst;
   logic        en;
   logic [15:0] divIn;
   logic        modeIn;
   logic        divLoad;
   logic        clkOut;
   logic        tick;
   logic        running;
   logic        pending;
   logic        cfgErr;

   int checks   = 0;
   int failures = 0;

   prog_clock_divider dut (
      .clkIn   (clkIn),
      .rst     (rst),
      .en      (en),
      .divIn   (divIn),
      .modeIn  (modeIn),
      .divLoad (divLoad),
      .clkOut  (clkOut),
      .tick    (tick),
      .running (running),
      .pending (pending),
      .cfgErr  (cfgErr)
   );

   initial clkIn = 1'b0;
   always #5 clkIn = ~clkIn;

   task automatic applyStimulus(input logic e, input logic ld, input logic [15:0] d, input logic m);
      en      = e;
      divLoad = ld;
      divIn   = d;
      modeIn  = m;
   endtask

   task automatic checkOutput(input string tag, input logic c, input logic t,
                              input logic r, input logic p, input logic e);
      checks++;
      assert (clkOut === c) else begin
         failures++;
         $error("[TB] FAIL %s clkOut got %b exp %b", tag, clkOut, c);
      end
      checks++;
      assert (tick === t) else begin
         failures++;
         $error("[TB] FAIL %s tick got %b exp %b", tag, tick, t);
      end
      checks++;
      assert (running === r) else begin
         failures++;
         $error("[TB] FAIL %s running got %b exp %b", tag, running, r);
      end
      checks++;
      assert (pending === p) else begin
         failures++;
         $error("[TB] FAIL %s pending got %b exp %b", tag, pending, p);
      end
      checks++;
      assert (cfgErr === e) else begin
         failures++;
         $error("[TB] FAIL %s cfgErr got %b exp %b", tag, cfgErr, e);
      end
   endtask

   // One clock edge, then check the outputs of the cycle that edge started
   task automatic cyc(input string tag, input logic c, input logic t,
                      input logic r, input logic p, input logic e);
      @(posedge clkIn);
      #1;
      checkOutput(tag, c, t, r, p, e);
   endtask

   initial begin
      rst = 1'b1;
      applyStimulus(1'b0, 1'b0, 16'd0, 1'b0);
      #1 rst = 1'b0;
      #2 checkOutput("reset", 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
      @(posedge clkIn);
      @(posedge clkIn);
      #1;
      checkOutput("resetHeld", 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
      rst = 1'b1;

      // Defaults: N = 4 square
      applyStimulus(1'b1, 1'b0, 16'd0, 1'b0);
      cyc("def0", 1, 1, 1, 0, 0);
      cyc("def1", 1, 0, 1, 0, 0);
      cyc("def2", 0, 0, 1, 0, 0);
      cyc("def3", 0, 0, 1, 0, 0);
      cyc("def4", 1, 1, 1, 0, 0);
      cyc("def5", 1, 0, 1, 0, 0);
      cyc("def6", 0, 0, 1, 0, 0);
      cyc("def7", 0, 0, 1, 0, 0);

      // Mid-period load of N = 5 square
      cyc("preB0", 1, 1, 1, 0, 0);
      cyc("preB1", 1, 0, 1, 0, 0);
      applyStimulus(1'b1, 1'b1, 16'd5, 1'b0);
      cyc("ld5a", 0, 0, 1, 1, 0);
      applyStimulus(1'b1, 1'b0, 16'd0, 1'b0);
      cyc("ld5b", 0, 0, 1, 1, 0);
      cyc("n5c0", 1, 1, 1, 0, 0);
      cyc("n5c1", 1, 0, 1, 0, 0);
      cyc("n5c2", 0, 0, 1, 0, 0);
      cyc("n5c3", 0, 0, 1, 0, 0);
      cyc("n5c4", 0, 0, 1, 0, 0);
      cyc("n5c0b", 1, 1, 1, 0, 0);

      // Load N = 3 pulse
      applyStimulus(1'b1, 1'b1, 16'd3, 1'b1);
      cyc("ld3a", 1, 0, 1, 1, 0);
      applyStimulus(1'b1, 1'b0, 16'd0, 1'b0);
      cyc("ld3b", 0, 0, 1, 1, 0);
      cyc("ld3c", 0, 0, 1, 1, 0);
      cyc("ld3d", 0, 0, 1, 1, 0);
      cyc("p3c0", 1, 1, 1, 0, 0);
      cyc("p3c1", 0, 0, 1, 0, 0);
      cyc("p3c2", 0, 0, 1, 0, 0);
      cyc("p3c0b", 1, 1, 1, 0, 0);
      cyc("p3c1b", 0, 0, 1, 0, 0);
      cyc("p3c2b", 0, 0, 1, 0, 0);

      // Load during the boundary cycle waits one more period
      applyStimulus(1'b1, 1'b1, 16'd4, 1'b0);
      cyc("bndLd0", 1, 1, 1, 1, 0);
      applyStimulus(1'b1, 1'b0, 16'd0, 1'b0);
      cyc("bndLd1", 0, 0, 1, 1, 0);
      cyc("bndLd2", 0, 0, 1, 1, 0);
      cyc("n4c0", 1, 1, 1, 0, 0);
      cyc("n4c1", 1, 0, 1, 0, 0);

      // Stop at cnt = 1 completes the period, then idles
      applyStimulus(1'b0, 1'b0, 16'd0, 1'b0);
      cyc("stop2", 0, 0, 1, 0, 0);
      cyc("stop3", 0, 0, 1, 0, 0);
      cyc("idle0", 0, 0, 0, 0, 0);
      cyc("idle1", 0, 0, 0, 0, 0);
      applyStimulus(1'b1, 1'b0, 16'd0, 1'b0);
      cyc("rst0", 1, 1, 1, 0, 0);
      cyc("rst1", 1, 0, 1, 0, 0);
      applyStimulus(1'b0, 1'b0, 16'd0, 1'b0);
      cyc("rstop2", 0, 0, 1, 0, 0);
      applyStimulus(1'b1, 1'b0, 16'd0, 1'b0);
      cyc("resume3", 0, 0, 1, 0, 0);
      cyc("resume0", 1, 1, 1, 0, 0);
      cyc("resume1", 1, 0, 1, 0, 0);

      // Invalid divisor sets cfgErr, period unchanged; valid load clears it
      applyStimulus(1'b1, 1'b1, 16'd1, 1'b0);
      cyc("bad2", 0, 0, 1, 0, 1);
      applyStimulus(1'b1, 1'b0, 16'd0, 1'b0);
      cyc("bad3", 0, 0, 1, 0, 1);
      cyc("bad0", 1, 1, 1, 0, 1);
      cyc("bad1", 1, 0, 1, 0, 1);
      cyc("bad2b", 0, 0, 1, 0, 1);
      cyc("bad3b", 0, 0, 1, 0, 1);
      cyc("bad0b", 1, 1, 1, 0, 1);
      applyStimulus(1'b1, 1'b1, 16'd6, 1'b0);
      cyc("ld6a", 1, 0, 1, 1, 0);
      applyStimulus(1'b1, 1'b0, 16'd0, 1'b0);
      cyc("ld6b", 0, 0, 1, 1, 0);
      cyc("ld6c", 0, 0, 1, 1, 0);
      cyc("n6c0", 1, 1, 1, 0, 0);
      cyc("n6c1", 1, 0, 1, 0, 0);
      cyc("n6c2", 1, 0, 1, 0, 0);
      cyc("n6c3", 0, 0, 1, 0, 0);
      cyc("n6c4", 0, 0, 1, 0, 0);
      cyc("n6c5", 0, 0, 1, 0, 0);
      cyc("n6c0b", 1, 1, 1, 0, 0);

      // Back to N = 5, then reset mid-period
      applyStimulus(1'b1, 1'b1, 16'd5, 1'b0);
      cyc("ld5r1", 1, 0, 1, 1, 0);
      applyStimulus(1'b1, 1'b0, 16'd0, 1'b0);
      cyc("ld5r2", 1, 0, 1, 1, 0);
      cyc("ld5r3", 0, 0, 1, 1, 0);
      cyc("ld5r4", 0, 0, 1, 1, 0);
      cyc("ld5r5", 0, 0, 1, 1, 0);
      cyc("r5c0", 1, 1, 1, 0, 0);
      cyc("r5c1", 1, 0, 1, 0, 0);
      cyc("r5c2", 0, 0, 1, 0, 0);
      rst = 1'b0;
      #1 checkOutput("asyncRst", 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
      @(posedge clkIn);
      #1;
      checkOutput("asyncRstHeld", 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
      rst = 1'b1;
      cyc("post0", 1, 1, 1, 0, 0);
      cyc("post1", 1, 0, 1, 0, 0);
      cyc("post2", 0, 0, 1, 0, 0);
      cyc("post3", 0, 0, 1, 0, 0);
      cyc("post0b", 1, 1, 1, 0, 0);
      cyc("post1b", 1, 0, 1, 0, 0);

      // Stop and load in the same cycle: load applied at the stop boundary
      applyStimulus(1'b0, 1'b1, 16'd3, 1'b0);
      cyc("sl2", 0, 0, 1, 1, 0);
      applyStimulus(1'b0, 1'b0, 16'd0, 1'b0);
      cyc("sl3", 0, 0, 1, 1, 0);
      cyc("slIdle", 0, 0, 0, 0, 0);
      applyStimulus(1'b1, 1'b0, 16'd0, 1'b0);
      cyc("s3c0", 1, 1, 1, 0, 0);
      applyStimulus(1'b0, 1'b0, 16'd0, 1'b0);
      cyc("s3c1", 0, 0, 1, 0, 0);
      cyc("s3c2", 0, 0, 1, 0, 0);
      cyc("s3Idle", 0, 0, 0, 0, 0);

      // Load in IDLE applies immediately without pending
      applyStimulus(1'b0, 1'b1, 16'd2, 1'b1);
      cyc("idleLd", 0, 0, 0, 0, 0);
      applyStimulus(1'b1, 1'b0, 16'd0, 1'b0);
      cyc("p2c0", 1, 1, 1, 0, 0);
      cyc("p2c1", 0, 0, 1, 0, 0);
      cyc("p2c0b", 1, 1, 1, 0, 0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule

// File: doc/prog_clock_divider.md
PROG_CLOCK_DIVIDER -- requirements
Module: prog_clock_divider

Interface
REQ-001 Parameter CNT_W, default 16: width of divisor and period counter.
REQ-002 Parameter DEF_DIV, default 4: divisor loaded at reset; SHALL be in the range 2..2^CNT_W-1.
REQ-003 Parameter DEF_MODE, default 0: mode loaded at reset (0 = square, 1 = pulse).
REQ-004 clkIn  input  1  sole clock; all state updates on its rising edge.
REQ-005 rst  input  1  asynchronous, active-low reset.
REQ-006 en  input  1  run request; 1 = divide, 0 = stop at the next period boundary.
REQ-007 divIn  input  CNT_W  new divisor N, sampled when divLoad = 1.
REQ-008 modeIn  input  1  new mode, sampled together with divIn.
REQ-009 divLoad  input  1  single-cycle load strobe.
REQ-010 clkOut  output  1  divided clock, registered.
REQ-011 tick  output  1  one-cycle pulse in each cycle where cnt = 0 while running.
REQ-012 running  output  1  high in states RUN and STOP.
REQ-013 pending  output  1  staged divisor/mode waiting for a period boundary.
REQ-014 cfgErr  output  1  sticky flag: last load carried an invalid divisor.

Function
REQ-015 FSM states SHALL be IDLE, RUN and STOP, with an internal counter cnt of CNT_W bits and active divisor N.
- IDLE -> RUN: en = 1.
- RUN -> STOP: en = 0.
- STOP -> RUN: en = 1, with no break in counting.
- STOP -> IDLE: boundary cycle reached (cnt = N-1).
REQ-016 In RUN/STOP, cnt SHALL advance by 1 per cycle and wrap from N-1 to 0; the first cycle after entering RUN from IDLE SHALL have cnt = 0.
REQ-017 Square mode: clkOut = 1 in cycles where cnt < N>>1, else 0. For odd N, clkOut is high for floor(N/2) cycles and low for the remainder.
REQ-018 Pulse mode: clkOut = 1 only in cycles where cnt = 0.
REQ-019 In IDLE, clkOut = 0, tick = 0 and cnt = 0. A stop SHALL never truncate a period or produce a glitch.
REQ-020 divLoad with 2 <= divIn SHALL write divIn/modeIn to a shadow register, set pending the next cycle and clear cfgErr.
REQ-021 The shadow SHALL be applied at the first boundary (cnt = N-1 -> 0) strictly after the load cycle, so the new N/mode govern the cycle with cnt = 0. pending SHALL clear in that same cycle.
REQ-022 In IDLE, a valid load SHALL be applied on the next edge; pending SHALL not assert.
REQ-023 divLoad with divIn < 2 SHALL be ignored (shadow, N and pending unchanged) and SHALL set cfgErr.
REQ-024 Repeated loads while pending SHALL overwrite the shadow; only the last valid load is applied.
REQ-025 en falling and divLoad in the same cycle: both SHALL take effect. The load is applied at the stop boundary and governs the next RUN.
REQ-026 No combinational path from any input to any output.

Reset
REQ-027 While rst = 0: state = IDLE, cnt = 0, N = shadow = DEF_DIV, mode = DEF_MODE.
REQ-028 While rst = 0: clkOut = tick = running = pending = cfgErr = 0.
REQ-029 Reset asserted mid-period SHALL force these values immediately, without waiting for a clock edge.
REQ-030 After rst deasserts, the block SHALL resume per REQ-015 from the first rising edge.

Configuration
REQ-031 Macro PROG_CLOCK_DIVIDER_PERIOD_CNT_EN, when defined, SHALL add output periodCnt (output, CNT_W bits).
- periodCnt increments in each tick cycle and wraps from 2^CNT_W-1 to 0.
- periodCnt resets to 0 and holds its value in IDLE.
REQ-032 Without PROG_CLOCK_DIVIDER_PERIOD_CNT_EN, the port and its logic SHALL be absent; all other behaviour is identical.

Verification
REQ-033 Reset, en = 1, defaults (N = 4, square) -> clkOut 1,1,0,0 repeating; tick every 4th cycle; running = 1.
REQ-034 Load N = 5, square, mid-period -> pending = 1 until boundary; then clkOut 1,1,0,0,0 repeating; pending = 0.
REQ-035 Load N = 3, modeIn = 1 -> after boundary clkOut 1,0,0 repeating, equal to tick.
REQ-036 en = 0 at cnt = 1 with N = 4 -> cycles with cnt = 2,3 complete, then IDLE with clkOut = 0; en = 1 during cnt = 2 -> no break.
REQ-037 Load divIn = 1 -> cfgErr = 1, output period unchanged; subsequent load of 6 -> cfgErr = 0.
REQ-038 rst pulsed low mid-period with N = 5 -> outputs 0 immediately; after release and en = 1, period is 4 (DEF_DIV).
